ebreak_halt_ctrl: RTL and testbench
===================================

# ebreak_halt_ctrl

Core-side initiator of the simulation-halt protocol. It watches the retire stage for an `ebreak`, freezes fetch, and waits for outstanding memory traffic to drain. It then raises the single-cycle `is_ebreak` strobe consumed by the DPI-C ebreak responder, together with the exit code (a0), the halting PC and performance counters. A no-retire watchdog forces the same halt sequence when the core hangs, so simulation always terminates.

## Interface
Parameters:
- `XLEN`, 64, datapath width of PC and a0.
- `WDT_CYCLES`, 1048576, consecutive no-retire cycles that trigger a forced halt; 0 disables the watchdog.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `retire_valid`  in  1  one instruction retires this cycle.
- `retire_is_ebreak`  in  1  the retiring instruction is `ebreak`; qualified by `retire_valid`.
- `retire_pc`  in  XLEN  PC of the retiring instruction.
- `a0_value`  in  XLEN  current architectural a0, bypassed to include the retiring instruction's write.
- `mem_busy`  in  1  IFU/LSU have outstanding bus transactions.
- `stall_fetch`  out  1  freeze fetch / stop issuing new instructions.
- `is_ebreak`  out  1  one-cycle halt strobe to the DPI-C responder.
- `halted`  out  1  core permanently halted until reset.
- `timeout`  out  1  halt was forced by the watchdog.
- `halt_code`  out  XLEN  exit code: latched a0, or all-ones on timeout.
- `halt_pc`  out  XLEN  PC of the ebreak, or of the last retired instruction on timeout.
- `cycle_count`  out  64  cycles elapsed in RUN and DRAIN.
- `instret`  out  64  instructions retired, including the ebreak.

## Operation
- The FSM has four states: RUN, DRAIN, SIGNAL, HALTED. Reset enters RUN.
- RUN
  - Each cycle: `cycle_count`+1. On `retire_valid`: `instret`+1, `last_pc`<=`retire_pc`, watchdog counter cleared.
  - Without `retire_valid`: watchdog counter +1, saturating.
  - On `retire_valid & retire_is_ebreak`: latch `halt_pc`=`retire_pc`, `halt_code`=`a0_value`, then go to DRAIN.
  - When `WDT_CYCLES`!=0, no retire occurs this cycle, and the watchdog counter equals `WDT_CYCLES`-1: latch `halt_pc`=`last_pc`, `halt_code`=all-ones, set `timeout`, then go to DRAIN.
- DRAIN
  - `cycle_count` keeps incrementing.
  - Retirements are ignored: no `instret` or latch update.
  - When `mem_busy`=0, go to SIGNAL. There is no drain limit.
- SIGNAL: `is_ebreak`=1 for this state only; next state is HALTED.
- HALTED: terminal until `rst`. Counters and latched values are frozen.
- `stall_fetch` = state!=RUN. `halted` = state==HALTED. All outputs are decoded from registers; no combinational input-to-output path.
- Counters are 64-bit and wrap modulo 2^64. The watchdog counter is ceil(log2(WDT_CYCLES+1)) bits.
- Simultaneous ebreak retire and watchdog expiry cannot coincide, because a retire clears the watchdog. The ebreak path wins and `timeout` stays 0.
- An `rst` assertion in any state, including mid-DRAIN or SIGNAL, immediately returns all outputs to reset values. No strobe is emitted.

## Timing
- Reset values: state RUN; `stall_fetch`=0, `is_ebreak`=0, `halted`=0, `timeout`=0, `halt_code`=0, `halt_pc`=0, `cycle_count`=0, `instret`=0, watchdog=0, `last_pc`=0.
- Ebreak sampled at edge T:
  - DRAIN from T+1, with `stall_fetch`=1 during cycle T+1.
  - If `mem_busy`=0 at edge T+1: `is_ebreak` is high for cycle T+2 only, and `halted`=1 from T+3.
  - Minimum retire-to-strobe latency is 2 cycles. Each additional `mem_busy` cycle adds 1.
- `is_ebreak` is never high for more than one cycle per reset epoch.
- `halt_code`, `halt_pc` and `timeout` are stable from T+1 onward, before the strobe.

## Test plan
- Basic halt: retire 3 normal instructions, then an ebreak at pc 0x80000010 with a0=0. Required: `is_ebreak` pulse exactly 2 cycles after the ebreak edge; `halt_pc`=0x80000010, `halt_code`=0, `instret`=4; `halted` stays 1 thereafter.
- Drain: ebreak with a0=0x2A while `mem_busy` is held 5 cycles. Required: pulse 7 cycles after retire; `stall_fetch` high throughout; `halt_code`=0x2A; retires injected during DRAIN leave `instret` unchanged.
- Watchdog: `WDT_CYCLES`=16, one retire at pc 0x100, then no retires. Required: `timeout`=1, `halt_code`=all-ones, `halt_pc`=0x100, pulse 2 cycles after expiry.
- Watchdog clear: `WDT_CYCLES`=16, retire every 15th cycle for 200 cycles. Required: no halt and `timeout`=0. Then set `WDT_CYCLES`=0 with no retires for 10000 cycles: no halt.
- Reset mid-DRAIN: ebreak with `mem_busy`=1, then assert `rst` during DRAIN. Required: all outputs return to zero asynchronously and no `is_ebreak` pulse. A subsequent ebreak halts normally.
- Counter freeze: after halting, wait 100 cycles. Required: `cycle_count` and `instret` unchanged, and `is_ebreak` never reasserts.

Source files
------------

// File: rtl/ebreak_halt_ctrl.sv
// Halt initiator: on ebreak retire (or no-retire watchdog expiry) freeze fetch,
// drain memory traffic, emit a one-cycle is_ebreak strobe, then halt for good.
module ebreak_halt_ctrl #(
  parameter int XLEN       = 64,
  parameter int WDT_CYCLES = 1048576
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            retire_valid,
  input  logic            retire_is_ebreak,
  input  logic [XLEN-1:0] retire_pc,
  input  logic [XLEN-1:0] a0_value,
  input  logic            mem_busy,
  output logic            stall_fetch,
  output logic            is_ebreak,
  output logic            halted,
  output logic            timeout,
  output logic [XLEN-1:0] halt_code,
  output logic [XLEN-1:0] halt_pc,
  output logic [63:0]     cycle_count,
  output logic [63:0]     instret
);

  localparam int WW = (WDT_CYCLES > 0) ? $clog2(WDT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    SIGNAL,
    HALTED
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [WW-1:0]   r_wdt;
  logic [XLEN-1:0] r_last_pc;
  logic [XLEN-1:0] r_code;
  logic [XLEN-1:0] r_pc;
  logic            r_timeout;
  logic [63:0]     r_cyc;
  logic [63:0]     r_ret;

  logic w_ebreak;
  logic w_wdt_exp;
  logic w_wdt_max;

  assign w_ebreak  = retire_valid & retire_is_ebreak;
  // A retire this cycle clears the watchdog, so ebreak always wins a tie.
  assign w_wdt_exp = (WDT_CYCLES != 0) && !retire_valid &&
                     (r_wdt == WW'(WDT_CYCLES - 1));
  assign w_wdt_max = (r_wdt == WW'(WDT_CYCLES));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RUN:     if (w_ebreak || w_wdt_exp) w_next = DRAIN;
      DRAIN:   if (!mem_busy) w_next = SIGNAL;
      SIGNAL:  w_next = HALTED;
      HALTED:  w_next = HALTED;
      default: w_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdt     <= '0;
      r_last_pc <= '0;
      r_code    <= '0;
      r_pc      <= '0;
      r_timeout <= 1'b0;
      r_cyc     <= '0;
      r_ret     <= '0;
    end else begin
      unique case (r_state)
        RUN: begin
          r_cyc <= r_cyc + 64'd1;
          if (retire_valid) begin
            r_ret     <= r_ret + 64'd1;
            r_last_pc <= retire_pc;
            r_wdt     <= '0;
          end else if (!w_wdt_max) begin
            r_wdt <= r_wdt + WW'(1);
          end
          if (w_ebreak) begin
            r_pc   <= retire_pc;
            r_code <= a0_value;
          end else if (w_wdt_exp) begin
            r_pc      <= r_last_pc;
            r_code    <= '1;
            r_timeout <= 1'b1;
          end
        end
        DRAIN:   r_cyc <= r_cyc + 64'd1;
        default: ;
      endcase
    end
  end

  assign stall_fetch = (r_state != RUN);
  assign is_ebreak   = (r_state == SIGNAL);
  assign halted      = (r_state == HALTED);
  assign timeout     = r_timeout;
  assign halt_code   = r_code;
  assign halt_pc     = r_pc;
  assign cycle_count = r_cyc;
  assign instret     = r_ret;

endmodule

// File: tb/tb_ebreak_halt_ctrl.sv
// Bench for ebreak_halt_ctrl: directed scenarios plus randomized epochs
// checked against a cycle-level behavioural model of the halt protocol.
module tb_ebreak_halt_ctrl;

  localparam int XLEN = 64;
  localparam int WDT  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rv  = 1'b0;
  logic reb = 1'b0;
  logic [63:0] rpc = '0;
  logic [63:0] a0  = '0;
  logic busy = 1'b0;

  logic stall, strb, hlt, tmo;
  logic [63:0] hcode, hpc, cyc, ret;
  logic d0_stall, d0_strb, d0_hlt, d0_tmo;
  logic [63:0] d0_hcode, d0_hpc, d0_cyc, d0_ret;

  always #5 clk = ~clk;

  ebreak_halt_ctrl #(.XLEN(XLEN), .WDT_CYCLES(WDT)) u_dut (
    .clk(clk), .rst(rst),
    .retire_valid(rv), .retire_is_ebreak(reb),
    .retire_pc(rpc), .a0_value(a0), .mem_busy(busy),
    .stall_fetch(stall), .is_ebreak(strb), .halted(hlt),
    .timeout(tmo), .halt_code(hcode), .halt_pc(hpc),
    .cycle_count(cyc), .instret(ret)
  );

  ebreak_halt_ctrl #(.XLEN(XLEN), .WDT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .retire_valid(rv), .retire_is_ebreak(reb),
    .retire_pc(rpc), .a0_value(a0), .mem_busy(busy),
    .stall_fetch(d0_stall), .is_ebreak(d0_strb), .halted(d0_hlt),
    .timeout(d0_tmo), .halt_code(d0_hcode), .halt_pc(d0_hpc),
    .cycle_count(d0_cyc), .instret(d0_ret)
  );

  int n_run  = 0;
  int n_fail = 0;

  // Behavioural model: "stopped" once a halt is requested, "done" once drained.
  logic [63:0] m_cyc, m_ret, m_last, m_code, m_pc;
  bit m_to, m_stop, m_done;
  int m_idle, m_edge, m_sig;
  int strobes, first_strb;

  task automatic model_reset();
    m_cyc = '0; m_ret = '0; m_last = '0; m_code = '0; m_pc = '0;
    m_to = 0; m_stop = 0; m_done = 0;
    m_idle = 0; m_edge = 0; m_sig = -1;
    strobes = 0; first_strb = -1;
  endtask

  function automatic bit e_strb();
    return m_done && (m_edge == m_sig);
  endfunction

  function automatic bit e_halt();
    return m_done && (m_edge > m_sig);
  endfunction

  task automatic step();
    @(posedge clk);
    m_edge++;
    if (!m_stop) begin
      m_cyc++;
      if (rv) begin
        m_ret++;
        m_last = rpc;
        m_idle = 0;
        if (reb) begin
          m_pc = rpc; m_code = a0; m_stop = 1;
        end
      end else begin
        m_idle++;
        if (m_idle == WDT) begin
          m_pc = m_last; m_code = '1; m_to = 1; m_stop = 1;
        end
      end
    end else if (!m_done) begin
      m_cyc++;
      if (!busy) begin
        m_done = 1; m_sig = m_edge;
      end
    end
    #1;
    if (strb) begin
      strobes++;
      if (first_strb < 0) first_strb = m_edge;
    end
  endtask

  task automatic idle_inputs();
    rv = 0; reb = 0; busy = 0; rpc = '0; a0 = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    #1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #2;
    n_run++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
    n_run++; if (strb !== 1'b0) begin n_fail++; $display("FAIL reset_strobe got %b want 0", strb); end
    n_run++; if (hlt !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", hlt); end
    n_run++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", tmo); end
    n_run++; if (hcode !== 64'd0) begin n_fail++; $display("FAIL reset_code got %h want 0", hcode); end
    n_run++; if (hpc !== 64'd0) begin n_fail++; $display("FAIL reset_pc got %h want 0", hpc); end
    n_run++; if (cyc !== 64'd0) begin n_fail++; $display("FAIL reset_cycles got %0d want 0", cyc); end
    n_run++; if (ret !== 64'd0) begin n_fail++; $display("FAIL reset_instret got %0d want 0", ret); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    int e;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      rv = 1; reb = 0; rpc = 64'h8000_0000 + 64'(4 * i); a0 = {$urandom, $urandom};
      step();
    end
    rv = 1; reb = 1; rpc = 64'h8000_0010; a0 = '0;
    step();
    e = m_edge;
    idle_inputs();
    n_run++;
    if ({stall, strb} !== 2'b10) begin
      n_fail++; $display("FAIL basic_drain_flags got %b want 10", {stall, strb});
    end
    for (int k = 0; k < 5; k++) step();
    n_run++;
    if (first_strb + 1 - e !== 2) begin
      n_fail++; $display("FAIL basic_latency got %0d want 2", first_strb + 1 - e);
    end
    n_run++; if (hpc !== 64'h8000_0010) begin n_fail++; $display("FAIL basic_pc got %h want 80000010", hpc); end
    n_run++; if (hcode !== 64'd0) begin n_fail++; $display("FAIL basic_code got %h want 0", hcode); end
    n_run++; if (ret !== 64'd4) begin n_fail++; $display("FAIL basic_instret got %0d want 4", ret); end
    n_run++; if (cyc !== m_cyc) begin n_fail++; $display("FAIL basic_cycles got %0d want %0d", cyc, m_cyc); end
    n_run++; if ({hlt, tmo} !== 2'b10) begin n_fail++; $display("FAIL basic_halted got %b want 10", {hlt, tmo}); end
  endtask

  task automatic test_counter_freeze();
    int bad;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      rv = 1'($urandom); reb = 1'($urandom); busy = 1'($urandom);
      rpc = {$urandom, $urandom}; a0 = {$urandom, $urandom};
      step();
      if (hlt !== 1'b1) bad++;
    end
    idle_inputs();
    n_run++; if (cyc !== m_cyc) begin n_fail++; $display("FAIL freeze_cycles got %0d want %0d", cyc, m_cyc); end
    n_run++; if (ret !== m_ret) begin n_fail++; $display("FAIL freeze_instret got %0d want %0d", ret, m_ret); end
    n_run++; if (strobes !== 1) begin n_fail++; $display("FAIL freeze_strobes got %0d want 1", strobes); end
    n_run++; if (bad !== 0) begin n_fail++; $display("FAIL freeze_halted got %0d unhalted cycles want 0", bad); end
  endtask

  task automatic test_drain();
    int e, bad;
    bad = 0;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      rv = 1; reb = 0; rpc = {$urandom, $urandom}; step();
    end
    rv = 1; reb = 1; rpc = 64'h8000_0200; a0 = 64'h2A; busy = 1;
    step();
    e = m_edge;
    for (int k = 0; k < 5; k++) begin
      rv = 1'($urandom); reb = 1'($urandom); rpc = {$urandom, $urandom}; a0 = {$urandom, $urandom};
      step();
      if ({stall, strb} !== 2'b10) bad++;
    end
    busy = 0; rv = 1; reb = 0;
    step();
    idle_inputs();
    for (int k = 0; k < 3; k++) step();
    n_run++; if (bad !== 0) begin n_fail++; $display("FAIL drain_stall got %0d bad cycles want 0", bad); end
    n_run++;
    if (first_strb + 1 - e !== 7) begin
      n_fail++; $display("FAIL drain_latency got %0d want 7", first_strb + 1 - e);
    end
    n_run++; if (hcode !== 64'h2A) begin n_fail++; $display("FAIL drain_code got %h want 2a", hcode); end
    n_run++; if (hpc !== 64'h8000_0200) begin n_fail++; $display("FAIL drain_pc got %h want 80000200", hpc); end
    n_run++; if (ret !== 64'd3) begin n_fail++; $display("FAIL drain_instret got %0d want 3", ret); end
    n_run++; if (cyc !== m_cyc) begin n_fail++; $display("FAIL drain_cycles got %0d want %0d", cyc, m_cyc); end
  endtask

  task automatic test_watchdog();
    int e;
    apply_reset();
    rv = 1; rpc = 64'h100; a0 = 64'h55;
    step();
    idle_inputs();
    e = m_edge + WDT;
    for (int k = 0; k < WDT + 6; k++) begin
      step();
      if (m_edge == e) begin
        n_run++;
        if ({stall, strb, tmo} !== 3'b101) begin
          n_fail++; $display("FAIL wdt_expiry_flags got %b want 101", {stall, strb, tmo});
        end
      end
    end
    n_run++; if (tmo !== 1'b1) begin n_fail++; $display("FAIL wdt_timeout got %b want 1", tmo); end
    n_run++; if (hcode !== '1) begin n_fail++; $display("FAIL wdt_code got %h want all-ones", hcode); end
    n_run++; if (hpc !== 64'h100) begin n_fail++; $display("FAIL wdt_pc got %h want 100", hpc); end
    n_run++;
    if (first_strb + 1 - e !== 2) begin
      n_fail++; $display("FAIL wdt_latency got %0d want 2", first_strb + 1 - e);
    end
    n_run++; if ({d0_hlt, d0_tmo} !== 2'b00) begin n_fail++; $display("FAIL wdt0_idle got %b want 00", {d0_hlt, d0_tmo}); end
  endtask

  task automatic test_wdt_clear();
    logic any;
    apply_reset();
    any = 1'b0;
    for (int c = 0; c < 200; c++) begin
      rv = (c % 15 == 14); rpc = {$urandom, $urandom};
      step();
      any = any | hlt | tmo | stall | strb;
    end
    n_run++; if (any !== 1'b0) begin n_fail++; $display("FAIL wdt_clear_halt got %b want 0", any); end
    n_run++; if (ret !== m_ret) begin n_fail++; $display("FAIL wdt_clear_instret got %0d want %0d", ret, m_ret); end
    apply_reset();
    any = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      step();
      any = any | d0_hlt | d0_tmo | d0_stall | d0_strb;
    end
    n_run++; if (any !== 1'b0) begin n_fail++; $display("FAIL wdt_off_halt got %b want 0", any); end
    n_run++; if (d0_cyc !== 64'd10000) begin n_fail++; $display("FAIL wdt_off_cycles got %0d want 10000", d0_cyc); end
    n_run++; if (tmo !== m_to) begin n_fail++; $display("FAIL wdt16_timeout got %b want %b", tmo, m_to); end
  endtask

  task automatic test_reset_mid_drain();
    int e;
    apply_reset();
    rv = 1; rpc = 64'h40; step();
    rv = 1; reb = 1; rpc = 64'h44; a0 = 64'h7; busy = 1; step();
    rv = 0; reb = 0;
    for (int k = 0; k < 3; k++) step();
    n_run++; if ({stall, strb} !== 2'b10) begin n_fail++; $display("FAIL mid_drain_state got %b want 10", {stall, strb}); end
    #2 rst = 1'b1;
    #1;
    n_run++;
    if ({stall, strb, hlt, tmo, hcode, hpc, cyc, ret} !== '0) begin
      n_fail++; $display("FAIL mid_drain_reset got stall=%b pc=%h cyc=%0d ret=%0d want all 0", stall, hpc, cyc, ret);
    end
    n_run++; if (strobes !== 0) begin n_fail++; $display("FAIL mid_drain_strobe got %0d want 0", strobes); end
    @(posedge clk); #1;
    n_run++; if ({stall, strb, cyc} !== '0) begin n_fail++; $display("FAIL mid_drain_held got stall=%b cyc=%0d want 0", stall, cyc); end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    model_reset();
    rv = 1; reb = 1; rpc = 64'hABC0; a0 = 64'h99;
    step();
    e = m_edge;
    idle_inputs();
    for (int k = 0; k < 4; k++) step();
    n_run++;
    if (first_strb + 1 - e !== 2) begin
      n_fail++; $display("FAIL post_reset_latency got %0d want 2", first_strb + 1 - e);
    end
    n_run++;
    if ({hpc, hcode} !== {64'hABC0, 64'h99}) begin
      n_fail++; $display("FAIL post_reset_latch got %h/%h want abc0/99", hpc, hcode);
    end
    n_run++; if (strobes !== 1) begin n_fail++; $display("FAIL post_reset_strobes got %0d want 1", strobes); end
  endtask

  task automatic test_random();
    int p;
    for (int ep = 0; ep < 8; ep++) begin
      apply_reset();
      p = (ep < 4) ? 60 : 7;
      for (int c = 0; c < 80; c++) begin
        rv   = ($urandom_range(0, 99) < p);
        reb  = rv && ($urandom_range(0, 99) < 5);
        rpc  = {$urandom, $urandom};
        a0   = {$urandom, $urandom};
        busy = ($urandom_range(0, 99) < 40);
        step();
        n_run++;
        if ({stall, strb, hlt, tmo} !== {m_stop, e_strb(), e_halt(), m_to}) begin
          n_fail++;
          $display("FAIL rand_flags ep%0d c%0d got %b want %b", ep, c,
                   {stall, strb, hlt, tmo}, {m_stop, e_strb(), e_halt(), m_to});
        end
        n_run++;
        if ({hcode, hpc} !== {m_code, m_pc}) begin
          n_fail++; $display("FAIL rand_latch ep%0d c%0d got %h/%h want %h/%h", ep, c, hcode, hpc, m_code, m_pc);
        end
        n_run++;
        if ({cyc, ret} !== {m_cyc, m_ret}) begin
          n_fail++; $display("FAIL rand_counts ep%0d c%0d got %0d/%0d want %0d/%0d", ep, c, cyc, ret, m_cyc, m_ret);
        end
      end
      n_run++;
      if (strobes > 1) begin n_fail++; $display("FAIL rand_strobes ep%0d got %0d want <=1", ep, strobes); end
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_counter_freeze();
    test_drain();
    test_watchdog();
    test_wdt_clear();
    test_reset_mid_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
